// File: rtl/mem_seg_pkg.sv
// Shared pipeline definitions: opcode constants, MEM-stage FSM states, branch resolution helper.
package mem_seg_pkg;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQZ = 6'b000100;
    localparam logic [5:0] OP_BNEZ = 6'b000101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    function automatic logic branch_taken(input logic [5:0] op, input logic cond);
        return ((op == OP_BEQZ) && cond) || ((op == OP_BNEZ) && !cond);
    endfunction

endpackage

// File: rtl/mem_seg_timeout_ctr.sv
// 4-bit wait-state counter for the MEM stage; expired_o flags the last allowed BUSY cycle.
module mem_timeout_ctr (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 4'hF);

endmodule

// File: rtl/mem_seg.sv
// MEM pipeline stage: issues loads/stores to data memory, resolves branches, fills MEM/WB.
module mem_seg
    import mem_seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        cond,
    input  logic [31:0] ALUi,
    input  logic [31:0] Bi,
    input  logic [31:0] IRi,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        valid_o,
    output logic [31:0] ALUo,
    output logic [31:0] LMDo,
    output logic [31:0] IRo,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        mem_err
);

    mem_state_e  state_q;
    logic        valid_q, br_taken_q, mem_req_q, mem_we_q, mem_err_q;
    logic [31:0] alu_q, lmd_q, ir_q, br_target_q, mem_addr_q, mem_wdata_q, ir_cap_q;

    logic [5:0] op;
    logic       is_mem, aligned, issue, ctr_en, expired;

    assign op      = IRi[31:26];
    assign is_mem  = (op == OP_LW) || (op == OP_SW);
    assign aligned = (ALUi[1:0] == 2'b00);
    assign issue   = (state_q == ST_IDLE) && in_valid && is_mem && aligned;
    assign ctr_en  = (state_q == ST_BUSY) && !mem_ack;

    mem_timeout_ctr u_timeout (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clr_i     (issue),
        .en_i      (ctr_en),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            alu_q       <= '0;
            lmd_q       <= '0;
            ir_q        <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ir_cap_q    <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            br_taken_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (issue) begin
                            state_q     <= ST_BUSY;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (op == OP_SW);
                            mem_addr_q  <= ALUi;
                            mem_wdata_q <= Bi;
                            ir_cap_q    <= IRi;
                        end else begin
                            // Misaligned memory ops retire immediately as errors, no request.
                            valid_q <= 1'b1;
                            alu_q   <= ALUi;
                            ir_q    <= IRi;
                            lmd_q   <= '0;
                            if (is_mem) begin
                                mem_err_q <= 1'b1;
                            end
                            if (branch_taken(op, cond)) begin
                                br_taken_q  <= 1'b1;
                                br_target_q <= ALUi;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack has priority over the timeout on the final counted cycle.
                    if (mem_ack || expired) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        valid_q   <= 1'b1;
                        alu_q     <= mem_addr_q;
                        ir_q      <= ir_cap_q;
                        lmd_q     <= (mem_ack && !mem_we_q) ? mem_rdata : '0;
                        if (!mem_ack) begin
                            mem_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall     = (state_q == ST_BUSY);
    assign valid_o   = valid_q;
    assign ALUo      = alu_q;
    assign LMDo      = lmd_q;
    assign IRo       = ir_q;
    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_seg.sv
// Directed self-checking bench for the MEM stage with hand-computed expectations.
module tb_mem_seg;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQZ = 6'b000100;
    localparam logic [5:0] BNEZ = 6'b000101;
    localparam logic [5:0] ADD  = 6'b000000;

    logic        clk, rst, in_valid, cond, mem_ack;
    logic [31:0] ALUi, Bi, IRi, mem_rdata;
    logic        stall, mem_req, mem_we, valid_o, br_taken, mem_err;
    logic [31:0] mem_addr, mem_wdata, ALUo, LMDo, IRo, br_target;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned busy_cnt;

    mem_seg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .cond      (cond),
        .ALUi      (ALUi),
        .Bi        (Bi),
        .IRi       (IRi),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .valid_o   (valid_o),
        .ALUo      (ALUo),
        .LMDo      (LMDo),
        .IRo       (IRo),
        .br_taken  (br_taken),
        .br_target (br_target),
        .mem_err   (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        in_valid = v;
        IRi      = {op, 26'h0000AB};
        ALUi     = a;
        Bi       = b;
        cond     = c;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stall"},   32'(stall),     32'd0);
        check_eq({tag, "_req"},     32'(mem_req),   32'd0);
        check_eq({tag, "_we"},      32'(mem_we),    32'd0);
        check_eq({tag, "_addr"},    mem_addr,       32'd0);
        check_eq({tag, "_wdata"},   mem_wdata,      32'd0);
        check_eq({tag, "_valid"},   32'(valid_o),   32'd0);
        check_eq({tag, "_alu"},     ALUo,           32'd0);
        check_eq({tag, "_lmd"},     LMDo,           32'd0);
        check_eq({tag, "_ir"},      IRo,            32'd0);
        check_eq({tag, "_brt"},     32'(br_taken),  32'd0);
        check_eq({tag, "_brtgt"},   br_target,      32'd0);
        check_eq({tag, "_err"},     32'(mem_err),   32'd0);
    endtask

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        #3;
        check_all_zero("reset");
        #10 rst = 1'b1;
        tick();

        // ADD: one-cycle pass-through
        drive(1'b1, ADD, 32'h0000_0010, 32'h0, 1'b0);
        tick();
        check_eq("add_valid", 32'(valid_o), 32'd1);
        check_eq("add_alu",   ALUo,         32'h10);
        check_eq("add_ir",    IRo,          {ADD, 26'h0000AB});
        check_eq("add_lmd",   LMDo,         32'h0);
        check_eq("add_stall", 32'(stall),   32'd0);
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("idle_valid", 32'(valid_o), 32'd0);
        check_eq("idle_hold",  ALUo,         32'h10);

        // Branches
        drive(1'b1, BEQZ, 32'h40, 32'h0, 1'b1);
        tick();
        check_eq("beqz_taken", 32'(br_taken), 32'd1);
        check_eq("beqz_tgt",   br_target,     32'h40);
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("beqz_pulse", 32'(br_taken), 32'd0);
        check_eq("beqz_hold",  br_target,     32'h40);
        drive(1'b1, BNEZ, 32'h80, 32'h0, 1'b1);
        tick();
        check_eq("bnez_c1_taken", 32'(br_taken), 32'd0);
        check_eq("bnez_c1_tgt",   br_target,     32'h40);
        check_eq("bnez_c1_valid", 32'(valid_o),  32'd1);
        drive(1'b1, BNEZ, 32'h84, 32'h0, 1'b0);
        tick();
        check_eq("bnez_c0_taken", 32'(br_taken), 32'd1);
        check_eq("bnez_c0_tgt",   br_target,     32'h84);

        // Stray ack while idle
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        check_eq("idle_ack_valid", 32'(valid_o), 32'd0);
        check_eq("idle_ack_stall", 32'(stall),   32'd0);
        check_eq("idle_ack_lmd",   LMDo,         32'h0);
        mem_ack = 1'b0;

        // LW with ack in the third BUSY cycle
        drive(1'b1, LW, 32'h100, 32'h0, 1'b0);
        tick();
        check_eq("lw_req",   32'(mem_req), 32'd1);
        check_eq("lw_we",    32'(mem_we),  32'd0);
        check_eq("lw_addr",  mem_addr,     32'h100);
        check_eq("lw_valid", 32'(valid_o), 32'd0);
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        busy_cnt = 32'(stall);
        tick(); busy_cnt += 32'(stall);
        check_eq("lw_req_hold", 32'(mem_req), 32'd1);
        tick(); busy_cnt += 32'(stall);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check_eq("lw_stall_cycles", busy_cnt, 32'd3);
        check_eq("lw_stall_drop",   32'(stall),   32'd0);
        check_eq("lw_valid_ret",    32'(valid_o), 32'd1);
        check_eq("lw_lmd",          LMDo,         32'hCAFE_F00D);
        check_eq("lw_alu",          ALUo,         32'h100);
        check_eq("lw_ir",           IRo,          {LW, 26'h0000AB});
        check_eq("lw_req_drop",     32'(mem_req), 32'd0);
        tick();
        check_eq("lw_valid_pulse",  32'(valid_o), 32'd0);

        // SW: request held stable while inputs change
        drive(1'b1, SW, 32'h104, 32'h1234, 1'b0);
        tick();
        check_eq("sw_we",    32'(mem_we), 32'd1);
        check_eq("sw_wdata", mem_wdata,   32'h1234);
        drive(1'b0, LW, 32'hDEAD_BEE0, 32'hDEAD_BEEF, 1'b0);
        tick();
        check_eq("sw_addr_stable",  mem_addr,     32'h104);
        check_eq("sw_wdata_stable", mem_wdata,    32'h1234);
        check_eq("sw_req_stable",   32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check_eq("sw_valid", 32'(valid_o), 32'd1);
        check_eq("sw_lmd",   LMDo,         32'h0);
        check_eq("sw_alu",   ALUo,         32'h104);
        check_eq("sw_err",   32'(mem_err), 32'd0);

        // Ack arriving on the last counted BUSY cycle wins over the timeout
        drive(1'b1, LW, 32'h180, 32'h0, 1'b0);
        tick();
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check_eq("edge_still_busy", 32'(stall), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        check_eq("edge_valid", 32'(valid_o), 32'd1);
        check_eq("edge_lmd",   LMDo,         32'h0BAD_F00D);
        check_eq("edge_err",   32'(mem_err), 32'd0);

        // Timeout: no ack at all
        drive(1'b1, LW, 32'h200, 32'h0, 1'b0);
        tick();
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        busy_cnt = 0;
        while (stall && busy_cnt < 40) begin
            busy_cnt++;
            tick();
        end
        check_eq("to_busy_cycles", busy_cnt,     32'd16);
        check_eq("to_req",         32'(mem_req), 32'd0);
        check_eq("to_err",         32'(mem_err), 32'd1);
        check_eq("to_valid",       32'(valid_o), 32'd1);
        check_eq("to_lmd",         LMDo,         32'h0);
        check_eq("to_alu",         ALUo,         32'h200);

        // Reset in the middle of a BUSY access
        drive(1'b1, LW, 32'h240, 32'h0, 1'b0);
        tick();
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("mid_busy_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        #1 rst = 1'b1;
        tick();
        check_eq("post_rst_req", 32'(mem_req), 32'd0);

        drive(1'b1, LW, 32'h300, 32'h0, 1'b0);
        tick();
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        check_eq("lw2_req",  32'(mem_req), 32'd1);
        check_eq("lw2_addr", mem_addr,     32'h300);
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        tick();
        mem_ack = 1'b0;
        check_eq("lw2_lmd",   LMDo,         32'h1357_9BDF);
        check_eq("lw2_valid", 32'(valid_o), 32'd1);

        // Misaligned LW: no request, immediate error retire
        drive(1'b1, LW, 32'h102, 32'h0, 1'b0);
        tick();
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        check_eq("mis_req",   32'(mem_req), 32'd0);
        check_eq("mis_stall", 32'(stall),   32'd0);
        check_eq("mis_err",   32'(mem_err), 32'd1);
        check_eq("mis_valid", 32'(valid_o), 32'd1);
        check_eq("mis_lmd",   LMDo,         32'h0);
        check_eq("mis_alu",   ALUo,         32'h102);
        drive(1'b1, ADD, 32'h8, 32'h0, 1'b0);
        tick();
        drive(1'b0, ADD, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("err_sticky", 32'(mem_err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
